// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and width for the shift-and-add multiplier
package mult_pkg;

   localparam int MULT_WIDTH = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CHECK,
      ST_ADD,
      ST_SHIFT,
      ST_DONE
   } mult_state_e;

endpackage

// File: rtl/mult_step_counter.sv
// rtl/mult_step_counter.sv - iteration counter with clear, increment and terminal flag
module mult_step_counter #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             k
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // k looks at the pre-increment value so the last SHIFT can both count and terminate
   assign count = count_q;
   assign k     = (count_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - Moore FSM sequencing load/add/shift over WIDTH multiplier bits
module shift_add_mult_ctrl
   import mult_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             q0,
   output logic             ld_op,
   output logic             add_en,
   output logic             shift_en,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] iter
);

   mult_state_e state_q;
   mult_state_e state_d;
   logic        cnt_clr;
   logic        cnt_inc;
   logic        cnt_k;

   mult_step_counter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .count (iter),
      .k     (cnt_k)
   );

   always_comb begin
      state_d = state_q;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            cnt_clr = 1'b1;
            state_d = ST_CHECK;
         end
         ST_CHECK: state_d = q0 ? ST_ADD : ST_SHIFT;
         ST_ADD:   state_d = ST_SHIFT;
         ST_SHIFT: begin
            cnt_inc = 1'b1;
            state_d = cnt_k ? ST_DONE : ST_CHECK;
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      // abort overrides every transition, including the terminal SHIFT -> DONE
      if (abort && (state_q != ST_IDLE)) begin
         state_d = ST_IDLE;
         cnt_clr = 1'b1;
         cnt_inc = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      ld_op    = 1'b0;
      add_en   = 1'b0;
      shift_en = 1'b0;
      done     = 1'b0;
      busy     = (state_q != ST_IDLE);
      case (state_q)
         ST_LOAD:  ld_op    = 1'b1;
         ST_ADD:   add_en   = 1'b1;
         ST_SHIFT: shift_en = 1'b1;
         ST_DONE:  done     = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - randomized self-checking bench for the multiplier control unit
module tb_shift_add_mult_ctrl;
   import mult_pkg::*;

   localparam int W  = MULT_WIDTH;
   localparam int CW = $clog2(W);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic          q0;
   logic          ld_op;
   logic          add_en;
   logic          shift_en;
   logic          busy;
   logic          done;
   logic [CW-1:0] iter;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [W-1:0]  mreg;

   shift_add_mult_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .q0       (q0),
      .ld_op    (ld_op),
      .add_en   (add_en),
      .shift_en (shift_en),
      .busy     (busy),
      .done     (done),
      .iter     (iter)
   );

   always #5 clk = ~clk;

   // 0 none, 1 load, 2 add, 3 shift, 4 done, 9 more than one strobe
   function automatic int obs_code();
      int n;
      n = int'(ld_op) + int'(add_en) + int'(shift_en) + int'(done);
      if (n > 1) return 9;
      if (ld_op) return 1;
      if (add_en) return 2;
      if (shift_en) return 3;
      if (done) return 4;
      return 0;
   endfunction

   always @(negedge clk) begin
      if (rst === 1'b0) begin
         n_assert++;
         if (obs_code() == 9 || (busy === 1'b0 && obs_code() != 0)) begin
            n_fail++;
            $display("FAIL strobe_onehot t=%0t: ld=%b add=%b sh=%b done=%b busy=%b, required at most one strobe and none when idle",
                     $time, ld_op, add_en, shift_en, done, busy);
         end
      end
   end

   // Runs one multiplication from an IDLE negedge; abort_pos < 0 means no abort.
   task automatic do_run(input logic [W-1:0] m, input int abort_pos, input bit noisy,
                         input bit hold, input string name);
      int exp_q[$];
      int nshift;
      int code;
      int done_pos;
      int exp_done_pos;
      exp_q = {};
      exp_q.push_back(1);
      exp_done_pos = 2;
      for (int i = 0; i < W; i++) begin
         exp_q.push_back(0);
         if (m[i]) exp_q.push_back(2);
         exp_q.push_back(3);
         exp_done_pos += 2 + int'(m[i]);
      end
      exp_q.push_back(4);
      exp_done_pos -= 1;

      n_assert++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s idle_before: busy=%b required 0", name, busy);
      end
      start = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      nshift   = 0;
      done_pos = -1;
      for (int pos = 0; pos < exp_q.size(); pos++) begin
         code = obs_code();
         n_assert++;
         if (code != exp_q[pos]) begin
            n_fail++;
            $display("FAIL %s strobe pos %0d: got code %0d required %0d", name, pos, code, exp_q[pos]);
         end
         n_assert++;
         if (iter !== CW'(nshift)) begin
            n_fail++;
            $display("FAIL %s iter pos %0d: got %0d required %0d", name, pos, iter, CW'(nshift));
         end
         n_assert++;
         if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy pos %0d: got %b required 1", name, pos, busy);
         end
         if (code == 4 && done_pos < 0) done_pos = pos;
         if (exp_q[pos] == 3) nshift++;
         if (code == 1) mreg = m;
         else if (code == 3) mreg = mreg >> 1;
         q0 = mreg[0];
         if (hold) start = 1'b1;
         else if (noisy && pos != exp_q.size() - 1 && pos != abort_pos) start = 1'($urandom_range(0, 1));
         else start = 1'b0;
         abort = (pos == abort_pos);
         @(negedge clk);
         abort = 1'b0;
         if (pos == abort_pos) begin
            n_assert++;
            if (busy !== 1'b0 || obs_code() != 0 || iter !== '0) begin
               n_fail++;
               $display("FAIL %s after_abort: busy=%b code=%0d iter=%0d required busy=0 code=0 iter=0",
                        name, busy, obs_code(), iter);
            end
            return;
         end
      end
      n_assert++;
      if (done_pos != exp_done_pos) begin
         n_fail++;
         $display("FAIL %s latency: done at %0d cycles after LOAD, required %0d", name, done_pos, exp_done_pos);
      end
      n_assert++;
      if (busy !== 1'b0 || obs_code() != 0) begin
         n_fail++;
         $display("FAIL %s idle_after_done: busy=%b code=%0d required busy=0 code=0", name, busy, obs_code());
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; abort = 1'b0; q0 = 1'b0; mreg = '0;
      #2 rst = 1'b1;
      #1;
      n_assert++;
      if (busy !== 1'b0 || ld_op !== 1'b0 || add_en !== 1'b0 || shift_en !== 1'b0 || done !== 1'b0 || iter !== '0) begin
         n_fail++;
         $display("FAIL reset_values: busy=%b ld=%b add=%b sh=%b done=%b iter=%0d required all 0",
                  busy, ld_op, add_en, shift_en, done, iter);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_assert++;
         if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: busy=%b required 0", busy);
         end
      end
   endtask

   task automatic test_example();
      do_run(4'b1011, -1, 1'b0, 1'b0, "example_1011");
   endtask

   task automatic test_extremes();
      do_run(4'b0000, -1, 1'b0, 1'b0, "mult_0000");
      do_run(4'b1111, -1, 1'b0, 1'b0, "mult_1111");
   endtask

   task automatic test_random();
      for (int r = 0; r < 12; r++) begin
         do_run(W'($urandom), -1, 1'b1, 1'b0, "random_noisy_start");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      for (int r = 0; r < 3; r++) begin
         do_run(W'($urandom), -1, 1'b0, 1'b1, "back_to_back");
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_abort_check();
      logic [W-1:0] m;
      m = W'($urandom);
      do_run(m, 3 + int'(m[0]), 1'b0, 1'b0, "abort_2nd_check");
      do_run(W'($urandom), -1, 1'b0, 1'b0, "run_after_abort");
   endtask

   task automatic test_abort_last_shift();
      logic [W-1:0] m;
      m = W'($urandom);
      do_run(m, 2 * W + $countones(m), 1'b0, 1'b0, "abort_last_shift");
      @(negedge clk);
      n_assert++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_last_shift_no_done: busy=%b done=%b required 0 0", busy, done);
      end
      do_run(W'($urandom), -1, 1'b0, 1'b0, "run_after_abort_last");
   endtask

   task automatic test_reset_mid_run();
      int  nsh;
      bit  hit;
      nsh = 0;
      hit = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         q0 = 1'($urandom_range(0, 1));
         if (shift_en === 1'b1) begin
            nsh++;
            if (nsh == 2) hit = 1'b1;
         end
         if (!hit) @(negedge clk);
      end
      n_assert++;
      if (!hit) begin
         n_fail++;
         $display("FAIL reset_mid_run_timeout: no second shift_en within 40 cycles, required one");
      end
      rst = 1'b1;
      #1;
      n_assert++;
      if (busy !== 1'b0 || ld_op !== 1'b0 || add_en !== 1'b0 || shift_en !== 1'b0 || done !== 1'b0 || iter !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_run: busy=%b ld=%b add=%b sh=%b done=%b iter=%0d required all 0",
                  busy, ld_op, add_en, shift_en, done, iter);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         n_assert++;
         if (busy !== 1'b0 || obs_code() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_run_idle: busy=%b code=%0d required 0 0", busy, obs_code());
         end
      end
      do_run(W'($urandom), -1, 1'b0, 1'b0, "run_after_reset");
   endtask

   initial begin
      test_reset();
      test_example();
      test_extremes();
      test_random();
      test_back_to_back();
      test_abort_check();
      test_abort_last_shift();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
